// File: rtl/sub_16b_seq.sv
// Multi-cycle subtractor: D = A - B - Bin, one DIGIT-bit slice per clock, LSB slice first.
// Optional add mode (D = A + B + Cin) is enabled by defining SUB_16B_SEQ_ADD_MODE_EN.
module sub_16b_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
`ifdef SUB_16B_SEQ_ADD_MODE_EN
  input  logic             i_add,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_d,
  output logic             o_bout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_add;
  logic             w_last;
  logic [DIGIT:0]   w_slice_ext;
  logic [WIDTH-1:0] w_result;
  logic             w_ovf;

`ifdef SUB_16B_SEQ_ADD_MODE_EN
  logic r_add;
  assign w_add = r_add;
`else
  assign w_add = 1'b0;
`endif

  assign w_last = (r_cnt == CW'(N - 1));

  // NOTE: always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_BUSY;
      S_BUSY:  if (w_last)  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Carry-out of the DIGIT+1-bit sum, or borrow as the sign of the DIGIT+1-bit difference.
  always_comb begin
    w_slice_ext = '0;
    if (w_add)
      w_slice_ext = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_borrow};
    else
      w_slice_ext = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]} - {{DIGIT{1'b0}}, r_borrow};
  end

  assign w_result = {w_slice_ext[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};

  always_comb begin
    w_ovf = 1'b0;
    if (w_add) w_ovf = (r_a_msb == r_b_msb) && (w_result[WIDTH-1] != r_a_msb);
    else       w_ovf = (r_a_msb != r_b_msb) && (w_result[WIDTH-1] != r_a_msb);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_d      <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
`ifdef SUB_16B_SEQ_ADD_MODE_EN
      r_add    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_borrow <= i_bin;
            r_a_msb  <= i_a[WIDTH-1];
            r_b_msb  <= i_b[WIDTH-1];
            r_cnt    <= '0;
`ifdef SUB_16B_SEQ_ADD_MODE_EN
            r_add    <= i_add;
`endif
          end
        end
        S_BUSY: begin
          r_a      <= r_a >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_res    <= w_result;
          r_borrow <= w_slice_ext[DIGIT];
          r_cnt    <= r_cnt + 1'b1;
          // Visible results change only here, so partial sums are never exposed.
          if (w_last) begin
            r_d    <= w_result;
            r_bout <= w_slice_ext[DIGIT];
            r_ovf  <= w_ovf;
            r_zero <= (w_result == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);
  assign o_d    = r_d;
  assign o_bout = r_bout;
  assign o_ovf  = r_ovf;
  assign o_zero = r_zero;

endmodule

// File: tb/tb_sub_16b_seq.sv
// Self-checking bench for sub_16b_seq: table-driven operations plus hand-written
// sequences for ignored starts and mid-operation reset.
module tb_sub_16b_seq;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        add;
    logic [15:0] exp_d;
    logic        exp_bout;
    logic        exp_ovf;
    logic        exp_zero;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        add = 1'b0;
  logic        busy, done, bout, ovf, zero;
  logic [15:0] d;

  int n_checks = 0;
  int n_errors = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sub_16b_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_bin   (bin),
`ifdef SUB_16B_SEQ_ADD_MODE_EN
    .i_add   (add),
`endif
    .o_busy  (busy),
    .o_done  (done),
    .o_d     (d),
    .o_bout  (bout),
    .o_ovf   (ovf),
    .o_zero  (zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start at the next edge; returns just after the accepting edge (edge 0).
  task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vbin, input logic vadd);
    a     = va;
    b     = vb;
    bin   = vbin;
    add   = vadd;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = ~va;
    b     = ~vb;
    bin   = ~vbin;
  endtask

  // Counts edges from acceptance (edge 0 counts as one) until o_done is seen.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!done && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int edges;
    issue(v.a, v.b, v.bin, v.add);
    check({v.name, " busy"}, 32'(busy), 32'd1);
    wait_done(edges);
    check({v.name, " latency"}, 32'(edges), 32'(N + 1));
    check({v.name, " d"},    32'(d),    32'(v.exp_d));
    check({v.name, " bout"}, 32'(bout), 32'(v.exp_bout));
    check({v.name, " ovf"},  32'(ovf),  32'(v.exp_ovf));
    check({v.name, " zero"}, 32'(zero), 32'(v.exp_zero));
    tick();
    check({v.name, " idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int edges;
    int n_done;

    vecs.push_back('{"basic",     16'h1234, 16'h0234, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"underflow", 16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"sgn_ovf",   16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"zero",      16'h5555, 16'h5555, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"bin_wrap",  16'h5555, 16'h5555, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"pos_neg",   16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"all_ones",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"mixed",     16'hABCD, 16'h1234, 1'b1, 1'b0, 16'h9998, 1'b0, 1'b0, 1'b0});
`ifdef SUB_16B_SEQ_ADD_MODE_EN
    vecs.push_back('{"add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{"add_cin",   16'h1234, 16'h0FFF, 1'b1, 1'b1, 16'h2234, 1'b0, 1'b0, 1'b0});
`endif

    // Reset state
    tick();
    tick();
    check("reset outputs", 32'({busy, done, bout, ovf, zero}), 32'd0);
    check("reset d", 32'(d), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle after reset", 32'({busy, done}), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Starts while BUSY (sampled at edges 2 and 4) are ignored
    issue(16'h1234, 16'h0234, 1'b0, 1'b0);
    tick();
    a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign done at edge4", 32'(done), 32'd1);
    check("ign d", 32'(d), 32'h1000);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) n_done++;
    end
    check("ign no second done", 32'(n_done), 32'd0);
    check("ign idle", 32'(busy), 32'd0);
    check("ign d held", 32'(d), 32'h1000);

    // Reset at edge 2 aborts the operation
    issue(16'hABCD, 16'h0001, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    check("abort outputs", 32'({busy, done, bout, ovf, zero}), 32'd0);
    check("abort d", 32'(d), 32'd0);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) n_done++;
    end
    check("abort no done", 32'(n_done), 32'd0);
    issue(16'h0010, 16'h0001, 1'b0, 1'b0);
    wait_done(edges);
    check("post-abort latency", 32'(edges), 32'(N + 1));
    check("post-abort d", 32'(d), 32'h000F);
    check("post-abort flags", 32'({bout, ovf, zero}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
